// File: rtl/mem_line_responder.sv
// Line-granular main-memory responder for L1 refills and dirty write-backs.
// Accepts one request at a time, waits a fixed per-type latency, then holds one response.
module mem_line_responder #(
    parameter int LINE_BITS     = 512,
    parameter int MEM_LINES     = 1024,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [31:0]          req_addr,
    input  logic [LINE_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_write,
    output logic                 resp_err,
    output logic [LINE_BITS-1:0] resp_rdata,
    output logic                 busy
);
    localparam int IDX_W   = $clog2(MEM_LINES);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [LINE_BITS-1:0] mem_q [MEM_LINES];

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 write_q;
    logic                 err_q;
    logic [IDX_W-1:0]     idx_q;
    logic [LINE_BITS-1:0] wdata_q;
    logic                 resp_valid_q;
    logic                 resp_write_q;
    logic                 resp_err_q;
    logic [LINE_BITS-1:0] resp_rdata_q;

    logic                 accept_d;
    logic                 expire_d;
    logic                 mem_we_d;
    logic                 err_d;
    logic [CNT_W-1:0]     lat_d;
    logic                 unused_addr_bits;

    assign accept_d = (state_q == IDLE) && req_valid;
    assign expire_d = (state_q == WAIT) && (cnt_q == CNT_W'(1));
    // Out-of-range lines are flagged, never folded onto a valid index.
    assign err_d    = req_addr[31:6] >= 26'(MEM_LINES);
    assign lat_d    = req_write ? CNT_W'(WRITE_LATENCY) : CNT_W'(READ_LATENCY);
    assign mem_we_d = !rst && expire_d && write_q && !err_q;
    assign unused_addr_bits = &{1'b0, req_addr[5:0]};

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_write = resp_write_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    // Backing store: never reset, written only on the commit edge of a valid write.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_d) begin
            write_q <= req_write;
            err_q   <= err_d;
            idx_q   <= req_addr[6+IDX_W-1:6];
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        cnt_q   <= lat_d;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (expire_d) begin
                        cnt_q        <= '0;
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_write_q <= write_q;
                        resp_err_q   <= err_q;
                        resp_rdata_q <= (write_q || err_q) ? '0 : mem_q[idx_q];
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_line_responder.sv
// Directed self-checking bench for mem_line_responder: refill, write-back, errors,
// back-pressure, reset mid-flight and streaming timing.
module tb_mem_line_responder;
    localparam int LB = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [31:0]   req_addr;
    logic [LB-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_write;
    logic          resp_err;
    logic [LB-1:0] resp_rdata;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [LB-1:0] pat_a5;
    logic [LB-1:0] pat_11;
    logic [LB-1:0] pat_22;
    logic [LB-1:0] pat_3c;
    logic [LB-1:0] pat_c3;
    logic [LB-1:0] pat_ff;
    logic [LB-1:0] zero_line;

    mem_line_responder #(
        .LINE_BITS(LB), .MEM_LINES(1024), .READ_LATENCY(4), .WRITE_LATENCY(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_err(resp_err), .resp_rdata(resp_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, wait for acceptance, then wait for the response (left pending).
    task automatic send_req(input logic w, input logic [31:0] a, input logic [LB-1:0] d,
                            output int lat);
        int n;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin tick(); lat++; end
        $display("txn: write=%0b addr=%h latency=%0d err=%0b", w, a, lat, resp_err);
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0;
        tick(); tick();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        total++; if (resp_write !== 1'b0) begin bad++; $display("FAIL reset_resp_write: got %b expected 0", resp_write); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
        total++; if (resp_rdata !== zero_line) begin bad++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        tick();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_write_read();
        int lat;
        send_req(1'b1, 32'h0000_0040, pat_a5, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        total++; if (resp_write !== 1'b1) begin bad++; $display("FAIL wr_resp_write: got %b expected 1", resp_write); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL wr_resp_err: got %b expected 0", resp_err); end
        total++; if (resp_rdata !== zero_line) begin bad++; $display("FAIL wr_rdata: got %h expected 0", resp_rdata); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b expected 1", busy); end
        consume();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL wr_ready_after: got %b expected 1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL wr_valid_after: got %b expected 0", resp_valid); end
        send_req(1'b0, 32'h0000_007F, zero_line, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL rd_latency: got %0d expected 4", lat); end
        total++; if (resp_write !== 1'b0) begin bad++; $display("FAIL rd_resp_write: got %b expected 0", resp_write); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rd_resp_err: got %b expected 0", resp_err); end
        total++; if (resp_rdata !== pat_a5) begin bad++; $display("FAIL rd_rdata: got %h expected %h", resp_rdata, pat_a5); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        send_req(1'b0, 32'h0000_0040, zero_line, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL bp_latency: got %0d expected 4", lat); end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, resp_valid); end
            total++; if (resp_rdata !== pat_a5) begin bad++; $display("FAIL bp_rdata[%0d]: got %h expected %h", i, resp_rdata, pat_a5); end
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, req_ready); end
        end
        consume();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after: got %b expected 1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_after: got %b expected 0", resp_valid); end
    endtask

    task automatic test_out_of_range();
        int lat;
        send_req(1'b1, 32'h0000_0000, pat_3c, lat);
        consume();
        send_req(1'b0, 32'h0001_0000, zero_line, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL oor_rd_latency: got %0d expected 4", lat); end
        total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL oor_rd_err: got %b expected 1", resp_err); end
        total++; if (resp_rdata !== zero_line) begin bad++; $display("FAIL oor_rd_rdata: got %h expected 0", resp_rdata); end
        consume();
        send_req(1'b1, 32'h0001_0000, pat_c3, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL oor_wr_latency: got %0d expected 2", lat); end
        total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL oor_wr_err: got %b expected 1", resp_err); end
        total++; if (resp_write !== 1'b1) begin bad++; $display("FAIL oor_wr_write: got %b expected 1", resp_write); end
        consume();
        // Line 1024 must not alias onto line 0.
        send_req(1'b0, 32'h0000_0000, zero_line, lat);
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL oor_line0_err: got %b expected 0", resp_err); end
        total++; if (resp_rdata !== pat_3c) begin bad++; $display("FAIL oor_line0_rdata: got %h expected %h", resp_rdata, pat_3c); end
        consume();
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        send_req(1'b1, 32'h0000_0140, pat_11, lat);
        consume();
        req_write = 1'b1; req_addr = 32'h0000_0140; req_wdata = pat_22; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmw_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmw_busy: got %b expected 0", busy); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rmw_valid: got %b expected 0", resp_valid); end
        for (int i = 0; i < 4; i++) tick();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rmw_valid_later: got %b expected 0", resp_valid); end
        send_req(1'b0, 32'h0000_0140, zero_line, lat);
        total++; if (resp_rdata !== pat_11) begin bad++; $display("FAIL rmw_line5: got %h expected %h", resp_rdata, pat_11); end
        consume();
    endtask

    task automatic test_req_ignored();
        int lat;
        int n;
        req_write = 1'b0; req_addr = 32'h0000_0040; req_wdata = zero_line; req_valid = 1'b1;
        tick();
        req_write = 1'b1; req_wdata = pat_ff;
        n = 0;
        while (!resp_valid && n < 50) begin
            req_addr = (n % 2 == 0) ? 32'h0000_0140 : 32'h0000_0180;
            tick();
            n++;
        end
        req_valid = 1'b0;
        total++; if (n !== 4) begin bad++; $display("FAIL ign_latency: got %0d expected 4", n); end
        total++; if (resp_write !== 1'b0) begin bad++; $display("FAIL ign_write: got %b expected 0", resp_write); end
        total++; if (resp_rdata !== pat_a5) begin bad++; $display("FAIL ign_rdata: got %h expected %h", resp_rdata, pat_a5); end
        consume();
        for (int i = 0; i < 6; i++) tick();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL ign_no_extra_resp: got %b expected 0", resp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy: got %b expected 0", busy); end
        send_req(1'b0, 32'h0000_0140, zero_line, lat);
        total++; if (resp_rdata !== pat_11) begin bad++; $display("FAIL ign_line5: got %h expected %h", resp_rdata, pat_11); end
        consume();
    endtask

    // Alternating write/read pairs to lines 0..7 with resp_ready held high.
    task automatic test_back_to_back();
        logic [LB-1:0] exp_rd;
        logic [LB-1:0] d;
        logic [31:0]   word;
        logic          exp_w;
        logic          w;
        logic          pre;
        logic          acc;
        logic          pending;
        int            cyc;
        int            prev_acc;
        int            prev_lat;
        int            n;
        int            line;
        cyc = 0; prev_acc = 0; prev_lat = 0; pending = 1'b0; exp_w = 1'b0; exp_rd = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            line = i / 2;
            w    = (i % 2 == 0);
            word = 32'h5A00_0000 + 32'(line);
            d    = {16{word}};
            req_write = w; req_addr = 32'(line) << 6; req_wdata = d; req_valid = 1'b1;
            acc = 1'b0; n = 0;
            while (!acc && n < 100) begin
                pre = req_ready;
                tick(); cyc++; n++;
                if (resp_valid) begin
                    total++; if (resp_write !== exp_w) begin bad++; $display("FAIL stream_write[%0d]: got %b expected %b", i - 1, resp_write, exp_w); end
                    total++; if (resp_rdata !== exp_rd) begin bad++; $display("FAIL stream_rdata[%0d]: got %h expected %h", i - 1, resp_rdata, exp_rd); end
                    pending = 1'b0;
                end
                if (pre) acc = 1'b1;
            end
            if (i > 0) begin
                // Accept edges sit L+1 idle cycles apart: L latency edges plus the consume edge.
                total++; if (cyc - prev_acc !== prev_lat + 2) begin bad++; $display("FAIL stream_spacing[%0d]: got %0d expected %0d", i, cyc - prev_acc, prev_lat + 2); end
                total++; if (pending !== 1'b0) begin bad++; $display("FAIL stream_missing_resp[%0d]: got %b expected 0", i - 1, pending); end
            end
            $display("txn: stream op=%0d write=%0b line=%0d accept_cycle=%0d", i, w, line, cyc);
            prev_acc = cyc;
            prev_lat = w ? 2 : 4;
            exp_w    = w;
            exp_rd   = w ? zero_line : d;
            pending  = 1'b1;
        end
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin tick(); n++; end
        total++; if (resp_rdata !== exp_rd) begin bad++; $display("FAIL stream_last_rdata: got %h expected %h", resp_rdata, exp_rd); end
        total++; if (n !== 4) begin bad++; $display("FAIL stream_last_latency: got %0d expected 4", n); end
        tick();
        resp_ready = 1'b0;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL stream_ready_end: got %b expected 1", req_ready); end
    endtask

    initial begin
        pat_a5 = {64{8'hA5}};
        pat_11 = {64{8'h11}};
        pat_22 = {64{8'h22}};
        pat_3c = {64{8'h3C}};
        pat_c3 = {64{8'hC3}};
        pat_ff = {64{8'hFF}};
        zero_line = '0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_wait();
        test_req_ignored();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
